insn_encoder: RTL

INSN_ENCODER -- requirements
Module: insn_encoder

---
 rtl/insn_encoder_pkg.sv | 53 +++++
 rtl/insn_encoder_pack.sv | 90 +++++++++
 rtl/insn_encoder.sv | 110 +++++++++++
 3 files changed

// File: rtl/insn_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder: request classes, ALU op codes
// (common with the decoder), base opcodes and the encoder FSM state type.
package insn_encoder_pkg;

    typedef enum logic [3:0] {
        FMT_R     = 4'd0,
        FMT_I     = 4'd1,
        FMT_LOAD  = 4'd2,
        FMT_S     = 4'd3,
        FMT_B     = 4'd4,
        FMT_LUI   = 4'd5,
        FMT_AUIPC = 4'd6,
        FMT_JAL   = 4'd7,
        FMT_JALR  = 4'd8
    } fmt_e;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLT  = 4'd2;
    localparam logic [3:0] ALU_SLTU = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_AND  = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [6:0] OPC_R     = 7'h33;
    localparam logic [6:0] OPC_I     = 7'h13;
    localparam logic [6:0] OPC_LOAD  = 7'h03;
    localparam logic [6:0] OPC_S     = 7'h23;
    localparam logic [6:0] OPC_B     = 7'h63;
    localparam logic [6:0] OPC_LUI   = 7'h37;
    localparam logic [6:0] OPC_AUIPC = 7'h17;
    localparam logic [6:0] OPC_JAL   = 7'h6F;
    localparam logic [6:0] OPC_JALR  = 7'h67;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    // True when v, read as a signed 32-bit value, fits a two's-complement field of 'bits' bits.
    function automatic logic fits_signed(input logic [31:0] v, input int bits);
        int sv;
        int lim;
        sv  = $signed(v);
        lim = 1 <<< (bits - 1);
        return (sv >= -lim) && (sv < lim);
    endfunction

endpackage

// File: rtl/insn_encoder_pack.sv
// Combinational RV32I packer: turns one request into a 32-bit instruction word plus an
// illegal flag covering bad ops, out-of-range immediates and unsupported funct3 values.
module insn_pack
    import insn_encoder_pkg::*;
(
    input  logic [3:0]  i_fmt,
    input  logic [3:0]  i_alu_op,
    input  logic [2:0]  i_funct3,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [31:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_illegal
);

    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic       w_shift;
    logic       w_bad_op;

    always_comb begin
        w_f3     = 3'd0;
        w_f7     = 7'h00;
        w_shift  = 1'b0;
        w_bad_op = 1'b0;
        case (i_alu_op)
            ALU_ADD:  w_f3 = 3'd0;
            ALU_SUB:  begin w_f3 = 3'd0; w_f7 = 7'h20; end
            ALU_SLT:  w_f3 = 3'd2;
            ALU_SLTU: w_f3 = 3'd3;
            ALU_XOR:  w_f3 = 3'd4;
            ALU_OR:   w_f3 = 3'd6;
            ALU_AND:  w_f3 = 3'd7;
            ALU_SLL:  begin w_f3 = 3'd1; w_shift = 1'b1; end
            ALU_SRL:  begin w_f3 = 3'd5; w_shift = 1'b1; end
            ALU_SRA:  begin w_f3 = 3'd5; w_f7 = 7'h20; w_shift = 1'b1; end
            default:  w_bad_op = 1'b1;
        endcase
    end

    always_comb begin
        o_word    = 32'd0;
        o_illegal = w_bad_op;
        case (i_fmt)
            FMT_R: o_word = {w_f7, i_rs2, i_rs1, w_f3, i_rd, OPC_R};
            FMT_I: begin
                if (w_shift) begin
                    o_word    = {w_f7, i_imm[4:0], i_rs1, w_f3, i_rd, OPC_I};
                    o_illegal = w_bad_op || (i_imm > 32'd31);
                end else begin
                    o_word    = {i_imm[11:0], i_rs1, w_f3, i_rd, OPC_I};
                    o_illegal = w_bad_op || (i_alu_op == ALU_SUB) || !fits_signed(i_imm, 12);
                end
            end
            FMT_LOAD: begin
                o_word    = {i_imm[11:0], i_rs1, i_funct3, i_rd, OPC_LOAD};
                o_illegal = w_bad_op || !fits_signed(i_imm, 12) || (i_funct3 == 3'd3)
                            || (i_funct3 == 3'd6) || (i_funct3 == 3'd7);
            end
            FMT_S: begin
                o_word    = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], OPC_S};
                o_illegal = w_bad_op || !fits_signed(i_imm, 12) || (i_funct3 > 3'd2);
            end
            FMT_B: begin
                o_word    = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3, i_imm[4:1], i_imm[11], OPC_B};
                o_illegal = w_bad_op || !fits_signed(i_imm, 13) || i_imm[0]
                            || (i_funct3 == 3'd2) || (i_funct3 == 3'd3);
            end
            FMT_LUI: begin
                o_word    = {i_imm[31:12], i_rd, OPC_LUI};
                o_illegal = w_bad_op || (i_imm[11:0] != 12'd0);
            end
            FMT_AUIPC: begin
                o_word    = {i_imm[31:12], i_rd, OPC_AUIPC};
                o_illegal = w_bad_op || (i_imm[11:0] != 12'd0);
            end
            FMT_JAL: begin
                o_word    = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, OPC_JAL};
                o_illegal = w_bad_op || !fits_signed(i_imm, 21) || i_imm[0];
            end
            FMT_JALR: begin
                o_word    = {i_imm[11:0], i_rs1, 3'd0, i_rd, OPC_JALR};
                o_illegal = w_bad_op || !fits_signed(i_imm, 12);
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/insn_encoder.sv
// Instruction encoder: accepts encode requests, writes one RV32I word every two cycles to
// sequential instruction-memory addresses, and stops in FULL once DEPTH words are written.
module insn_encoder
    import insn_encoder_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clear,
    input  logic        i_req_vld,
    output logic        o_req_rdy,
    input  logic [3:0]  i_fmt,
    input  logic [3:0]  i_alu_op,
    input  logic [2:0]  i_funct3,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [31:0] i_imm,
    output logic        o_imem_wren,
    output logic [31:0] o_imem_addr,
    output logic [31:0] o_imem_wdata,
    output logic        o_err,
    output logic [16:0] o_count,
    output logic        o_full
);

    localparam logic [16:0] DEPTH_C = 17'(DEPTH);

    state_e      r_state;
    state_e      w_next;
    logic [31:0] r_addr;
    logic [16:0] r_count;
    logic [31:0] r_wdata;
    logic        r_err;
    logic        r_run;
    logic [31:0] w_word;
    logic        w_illegal;
    logic        w_xfer;
    logic        w_accept;
    logic [16:0] w_count_inc;

    insn_pack u_pack (
        .i_fmt     (i_fmt),
        .i_alu_op  (i_alu_op),
        .i_funct3  (i_funct3),
        .i_rd      (i_rd),
        .i_rs1     (i_rs1),
        .i_rs2     (i_rs2),
        .i_imm     (i_imm),
        .o_word    (w_word),
        .o_illegal (w_illegal)
    );

    assign w_xfer      = i_req_vld && o_req_rdy;
    assign w_accept    = w_xfer && !w_illegal && !i_clear;
    assign w_count_inc = r_count + 17'd1;

    always_comb begin
        w_next      = r_state;
        o_req_rdy   = 1'b0;
        o_imem_wren = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // r_run holds off the handshake until the first edge after reset release
                o_req_rdy = r_run;
                if (w_accept) w_next = ST_WRITE;
            end
            ST_WRITE: begin
                o_imem_wren = 1'b1;
                if (i_clear)                     w_next = ST_IDLE;
                else if (w_count_inc == DEPTH_C) w_next = ST_FULL;
                else                             w_next = ST_IDLE;
            end
            ST_FULL: if (i_clear) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_addr  <= BASE_ADDR;
            r_count <= 17'd0;
            r_wdata <= 32'd0;
            r_err   <= 1'b0;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_run   <= 1'b1;
            r_err   <= w_xfer && w_illegal && !i_clear;
            if (w_accept) r_wdata <= w_word;
            if (i_clear) begin
                r_addr  <= BASE_ADDR;
                r_count <= 17'd0;
            end else if (r_state == ST_WRITE) begin
                r_addr  <= r_addr + 32'd4;
                r_count <= w_count_inc;
            end
        end
    end

    assign o_imem_addr  = r_addr;
    assign o_imem_wdata = r_wdata;
    assign o_err        = r_err;
    assign o_count      = r_count;
    assign o_full       = (r_count == DEPTH_C);

endmodule
